// File: rtl/board_io_pkg.sv
// Shared board I/O constants: debounce default and channel indices for the
// switch/button conditioning block.
package board_io_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

    localparam int unsigned CH_SW_WR = 0;
    localparam int unsigned CH_SW_RD = 1;
    localparam int unsigned CH_BTN   = 2;
    localparam int unsigned NUM_CH   = 3;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchronizer, stability counter and registered
// rise/fall pulses on each accepted level change.
module debounce_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync0_q, sync1_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync1_q != stable_q) begin
            // The level is only accepted once it has differed for DEBOUNCE_CYCLES edges.
            if (cnt_q == CntMax) begin
                stable_d = sync1_q;
                rise_d   = sync1_q;
                fall_d   = ~sync1_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync0_q  <= 1'b0;
            sync1_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync0_q  <= raw;
            sync1_q  <= sync0_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces the two slide switches and the push button through three
// independent channels; all outputs come straight from channel flops.
module input_debouncer
    import board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] sw_raw,
    input  logic       btn_raw,
    output logic [1:0] sw_clean,
    output logic [1:0] sw_changed,
    output logic       btn_level,
    output logic       btn_press
);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic              unused_btn_fall;

    always_comb begin
        raw           = '0;
        raw[CH_SW_WR] = sw_raw[0];
        raw[CH_SW_RD] = sw_raw[1];
        raw[CH_BTN]   = btn_raw;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clock(clock),
            .reset(reset),
            .raw  (raw[g]),
            .level(level[g]),
            .rise (rise[g]),
            .fall (fall[g])
        );
    end

    assign sw_clean   = {level[CH_SW_RD], level[CH_SW_WR]};
    assign sw_changed = {rise[CH_SW_RD] | fall[CH_SW_RD], rise[CH_SW_WR] | fall[CH_SW_WR]};
    assign btn_level  = level[CH_BTN];
    assign btn_press  = rise[CH_BTN];

    // Button release is deliberately silent.
    assign unused_btn_fall = fall[CH_BTN];

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed scenarios with literal
// expectations plus randomized bouncing against a window-based reference model.
module tb_input_debouncer;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] sw_raw;
    logic       btn_raw;
    logic [1:0] sw_clean;
    logic [1:0] sw_changed;
    logic       btn_level;
    logic       btn_press;

    input_debouncer #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .btn_raw   (btn_raw),
        .sw_clean  (sw_clean),
        .sw_changed(sw_changed),
        .btn_level (btn_level),
        .btn_press (btn_press)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a channel accepts a new level when the synchronized value
    // seen at the last N edges (since reset) all differ from the accepted level.
    bit m_s0 [3];
    bit m_s1 [3];
    bit m_stable [3];
    bit m_acc [3];
    bit m_win [3][$];
    bit model_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_edge(input bit [2:0] r, input bit rst);
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                m_s0[c] = 1'b0;
                m_s1[c] = 1'b0;
                m_stable[c] = 1'b0;
                m_acc[c] = 1'b0;
                m_win[c].delete();
            end else begin
                bit used;
                bit all_diff;
                used = m_s1[c];
                m_s1[c] = m_s0[c];
                m_s0[c] = r[c];
                m_win[c].push_back(used);
                if (m_win[c].size() > N) void'(m_win[c].pop_front());
                m_acc[c] = 1'b0;
                if (m_win[c].size() == N) begin
                    all_diff = 1'b1;
                    foreach (m_win[c][k]) if (m_win[c][k] == m_stable[c]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_stable[c] = ~m_stable[c];
                        m_acc[c] = 1'b1;
                    end
                end
            end
        end
        if (rst) model_valid = 1'b1;
    endfunction

    task automatic step();
        bit [2:0] r;
        bit       rst;
        r   = {btn_raw, sw_raw[1], sw_raw[0]};
        rst = reset;
        @(posedge clock);
        model_edge(r, rst);
        #1;
        if (model_valid) begin
            check("model_sw_clean", 32'(sw_clean), 32'({m_stable[1], m_stable[0]}));
            check("model_sw_changed", 32'(sw_changed), 32'({m_acc[1], m_acc[0]}));
            check("model_btn_level", 32'(btn_level), 32'(m_stable[2]));
            check("model_btn_press", 32'(btn_press), 32'(m_acc[2] & m_stable[2]));
        end
    endtask

    task automatic do_reset();
        sw_raw  = 2'b00;
        btn_raw = 1'b0;
        reset   = 1'b1;
        step();
        reset   = 1'b0;
    endtask

    initial begin
        int presses;
        int p;
        reset   = 1'b1;
        sw_raw  = 2'b00;
        btn_raw = 1'b0;
        step();
        step();
        check("reset_state", 32'({sw_clean, sw_changed, btn_level, btn_press}), 32'd0);
        reset = 1'b0;

        // Clean step on the write-select switch.
        sw_raw = 2'b01;
        repeat (5) step();
        check("step_before_edge6", 32'(sw_clean), 32'd0);
        step();
        check("step_clean_edge6", 32'(sw_clean), 32'b01);
        check("step_changed_edge6", 32'(sw_changed), 32'b01);
        step();
        check("step_changed_edge7", 32'(sw_changed), 32'b00);
        check("step_clean_edge7", 32'(sw_clean), 32'b01);

        // Button toggling then held.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            btn_raw = (i % 2 == 0);
            step();
            check("toggle_no_press", 32'(btn_press), 32'd0);
        end
        btn_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_no_press_yet", 32'(btn_press), 32'd0);
        end
        step();
        check("hold_press", 32'(btn_press), 32'd1);

        // Long hold then release.
        do_reset();
        btn_raw = 1'b1;
        presses = 0;
        repeat (50) begin
            step();
            presses += int'(btn_press);
        end
        check("long_hold_one_press", 32'(presses), 32'd1);
        btn_raw = 1'b0;
        repeat (5) step();
        check("release_level_still_1", 32'(btn_level), 32'd1);
        step();
        check("release_level_0", 32'(btn_level), 32'd0);
        check("release_no_press", 32'(btn_press), 32'd0);

        // Both switches at once.
        do_reset();
        sw_raw = 2'b11;
        repeat (5) step();
        step();
        check("dual_clean", 32'(sw_clean), 32'b11);
        check("dual_changed", 32'(sw_changed), 32'b11);

        // Reset mid-count with the input still held.
        do_reset();
        sw_raw = 2'b10;
        repeat (3) step();
        reset = 1'b1;
        step();
        check("midreset_outputs", 32'({sw_clean, sw_changed, btn_level, btn_press}), 32'd0);
        reset = 1'b0;
        repeat (5) step();
        check("midreset_before_accept", 32'(sw_clean[1]), 32'd0);
        step();
        check("midreset_accept", 32'(sw_clean[1]), 32'd1);
        check("midreset_pulse", 32'(sw_changed), 32'b10);

        // Randomized bouncing with occasional resets.
        p = 10;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0: p = 2;
                    1: p = 12;
                    default: p = 45;
                endcase
            end
            if ($urandom_range(0, 99) < p) sw_raw[0] = ~sw_raw[0];
            if ($urandom_range(0, 99) < p) sw_raw[1] = ~sw_raw[1];
            if ($urandom_range(0, 99) < p) btn_raw = ~btn_raw;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable cycles required to accept a level change (board top overrides to 1_000_000); legal range 2..2^20.
REQ-002 SHALL have port clock  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sw_raw  input  2  asynchronous slide-switch levels; bit0 = write-block select, bit1 = read-block select.
REQ-005 SHALL have port btn_raw  input  1  asynchronous push-button level, 1 = pressed.
REQ-006 SHALL have port sw_clean  output  2  debounced switch levels; drives the display block's switch0/switch1 and the memory controller selects.
REQ-007 SHALL have port sw_changed  output  2  one-cycle pulse per bit when sw_clean bit toggles.
REQ-008 SHALL have port btn_level  output  1  debounced button level.
REQ-009 SHALL have port btn_press  output  1  one-cycle pulse on debounced button 0->1 transition.

Function
REQ-010 SHALL process three independent identical channels (sw_raw[0], sw_raw[1], btn_raw); no cross-channel coupling.
REQ-011 SHALL pass each raw input through a 2-flop synchronizer (sync0, sync1) before any other use.
REQ-012 SHALL hold per channel a stable register and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-013 SHALL, at each edge where sync1 == stable, clear the counter to 0.
REQ-014 SHALL, at each edge where sync1 != stable and counter < DEBOUNCE_CYCLES-1, increment the counter.
REQ-015 SHALL, at each edge where sync1 != stable and counter == DEBOUNCE_CYCLES-1, load stable <= sync1 and clear the counter.
REQ-016 SHALL give latency: a clean step first sampled into sync0 at edge 1 appears on the stable output after edge DEBOUNCE_CYCLES+2.
REQ-017 SHALL treat any return of sync1 to the stable value before acceptance as a bounce: counter restarts from 0; the output does not change.
REQ-018 SHALL assert the change/press pulse registered in the same cycle that stable updates, for exactly one cycle; never for consecutive cycles.
REQ-019 SHALL assert btn_press only on 0->1 transitions; release (1->0) produces no pulse; a held button produces one pulse.
REQ-020 SHALL assert sw_changed[i] on both rising and falling acceptance of sw_clean[i].
REQ-021 SHALL allow simultaneous acceptance on several channels in one cycle, each pulsing independently.
REQ-022 SHALL drive all outputs directly from flops (no combinational path from inputs).

Reset
REQ-023 SHALL, while reset = 1 at a posedge, clear sync0, sync1, stable, counter and all pulse flops of every channel to 0.
REQ-024 SHALL take sw_clean = 2'b00, sw_changed = 2'b00, btn_level = 0, btn_press = 0 during the cycle after any reset edge.
REQ-025 SHALL discard in-progress counts on reset asserted mid-count; counting restarts after release with no pulse from pre-reset activity.
REQ-026 SHALL, if an input is held at 1 through reset release, accept it after DEBOUNCE_CYCLES+2 edges and pulse once.

Structure
REQ-027 SHALL place DEBOUNCE_CYCLES default and the channel index constants (CH_SW_WR = 0, CH_SW_RD = 1, CH_BTN = 2) in shared package board_io_pkg.
REQ-028 SHALL implement one channel as sub-module debounce_channel (ports clock, reset, raw, level, rise, fall), instantiated three times.

Verification (DEBOUNCE_CYCLES = 4)
REQ-029 SHALL check: sw_raw[0] 0->1 clean step, first sampled at edge 1 -> sw_clean[0] = 1 after edge 6, sw_changed[0] high exactly one cycle, sw_clean[1] unchanged.
REQ-030 SHALL check: btn_raw toggles 1,0,1,0 on alternate cycles then holds 1 -> no btn_press during toggling; single btn_press 6 edges after the final hold begins.
REQ-031 SHALL check: btn_raw held 1 for 50 cycles, then released -> exactly one btn_press; btn_level falls 6 edges after release with no pulse.
REQ-032 SHALL check: sw_raw = 2'b11 applied in one cycle -> sw_clean = 2'b11 and sw_changed = 2'b11 on the same cycle.
REQ-033 SHALL check: sw_raw[1] goes 1, reset asserted 3 cycles later for 1 cycle -> all outputs 0 after the reset edge; sw_clean[1] = 1 six edges after reset release.
